// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-SRAM request/response and FpD delivery handshake.
interface fetch_stage_if #(parameter int FpD_W = 75);
  logic             inst_req;
  logic [31:0]      inst_addr;
  logic             inst_addr_ok;
  logic             inst_data_ok;
  logic [31:0]      inst_rdata;
  logic             FpD_valid;
  logic [FpD_W-1:0] FpD_BUS;
  logic             pD_allowin;
  modport master (
    output inst_req, inst_addr, FpD_valid, FpD_BUS,
    input  inst_addr_ok, inst_data_ok, inst_rdata, pD_allowin
  );
  modport slave (
    input  inst_req, inst_addr, FpD_valid, FpD_BUS,
    output inst_addr_ok, inst_data_ok, inst_rdata, pD_allowin
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner; one outstanding SRAM fetch, prioritized redirects, one-entry FpD output buffer.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter int          FpD_W    = 75
) (
  input  logic          clk,
  input  logic          rstn,
  fetch_stage_if.master bus,
  input  logic [32:0]   predict_BUS,
  input  logic          BTB_stall,
  input  logic          predict_error_D,
  input  logic [31:0]   br_target_D,
  input  logic          predict_error_E,
  input  logic [31:0]   br_target_E,
  input  logic          ex_en,
  input  logic [31:0]   ex_entry,
  input  logic          ertn_flush,
  input  logic [31:0]   era
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_HALT} state_t;
  state_t           r_state, w_state;
  logic [31:0]      r_pc, w_pc, w_target;
  logic             r_cancel, w_cancel, r_pred_used, w_pred_used, r_btb, w_btb;
  logic [FpD_W-1:0] r_bus, w_bus;
  logic             w_hard, w_redir, w_stall, w_req, w_valid;
  assign w_hard   = ex_en | ertn_flush | predict_error_E | predict_error_D;
  // after an ADEF only exception entry or ertn can restart fetch
  assign w_redir  = (r_state == S_HALT) ? (ex_en | ertn_flush)
                                         : (w_hard | (predict_BUS[32] & ~r_pred_used));
  assign w_target = ex_en ? ex_entry : ertn_flush ? era : predict_error_E ? br_target_E :
                    predict_error_D ? br_target_D : predict_BUS[31:0];
  assign w_stall  = BTB_stall | r_btb;
  assign w_req    = rstn && r_state == S_REQ && !w_stall && r_pc[1:0] == 2'b00;
  assign w_valid  = r_state == S_HOLD && !w_stall;
  assign bus.inst_req  = w_req;
  assign bus.inst_addr = r_pc;
  assign bus.FpD_valid = w_valid;
  assign bus.FpD_BUS   = r_bus;
  always_comb begin
    w_state     = r_state;
    w_pc        = r_pc;
    w_cancel    = r_cancel;
    w_pred_used = r_pred_used;
    w_bus       = r_bus;
    w_btb       = w_redir ? (r_btb & ~w_hard) : (r_btb | BTB_stall);
    case (r_state)
      S_REQ:
        if (w_req && bus.inst_addr_ok) begin
          w_state  = S_WAIT;
          w_cancel = w_redir;
        end else if (!w_stall && !w_redir && r_pc[1:0] != 2'b00) begin
          w_state = S_HOLD;
          w_bus   = {r_pc, 32'h0, 1'b1, 1'b1, 8'h08, 1'b0};
        end
      S_WAIT:
        if (bus.inst_data_ok) begin
          w_cancel = 1'b0;
          w_state  = (r_cancel || w_redir) ? S_REQ : S_HOLD;
          if (!r_cancel && !w_redir) w_bus = {r_pc, bus.inst_rdata, 1'b1, 1'b0, 8'h00, 1'b0};
        end else if (w_redir) begin
          w_cancel = 1'b1;
        end
      S_HOLD:
        if (w_redir) begin
          w_state = S_REQ;
        end else if (w_valid && bus.pD_allowin) begin
          w_state     = r_bus[9] ? S_HALT : S_REQ;
          w_pc        = r_bus[9] ? r_pc : r_pc + 32'd4;
          w_pred_used = 1'b0;
        end
      default:
        if (w_redir) w_state = S_REQ;
    endcase
    if (w_redir) begin
      w_pc        = w_target;
      w_pred_used = ~w_hard;
    end
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= S_REQ;
      r_pc        <= RESET_PC;
      r_cancel    <= 1'b0;
      r_pred_used <= 1'b0;
      r_btb       <= 1'b0;
      r_bus       <= '0;
    end else begin
      r_state     <= w_state;
      r_pc        <= w_pc;
      r_cancel    <= w_cancel;
      r_pred_used <= w_pred_used;
      r_btb       <= w_btb;
      r_bus       <= w_bus;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: redirect-priority vector table plus directed multi-cycle fetch sequences.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rstn;
  logic [32:0] predict_BUS;
  logic        BTB_stall, predict_error_D, predict_error_E, ex_en, ertn_flush;
  logic [31:0] br_target_D, br_target_E, ex_entry, era;
  int          n_tests = 0, n_fail = 0, n_req = 0, dcount = 0;
  logic [74:0] d_bus;
  fetch_stage_if ifc ();
  fetch_stage dut (
    .clk(clk), .rstn(rstn), .bus(ifc), .predict_BUS(predict_BUS), .BTB_stall(BTB_stall),
    .predict_error_D(predict_error_D), .br_target_D(br_target_D),
    .predict_error_E(predict_error_E), .br_target_E(br_target_E),
    .ex_en(ex_en), .ex_entry(ex_entry), .ertn_flush(ertn_flush), .era(era)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        ex, er, pe, pd, pt;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[8];
  function automatic logic [74:0] nbus(input logic [31:0] pc);
    return {pc, ~pc, 1'b1, 1'b0, 8'h00, 1'b0};
  endfunction
  task automatic chk(input string nm, input logic [74:0] act, input logic [74:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  // ideal SRAM: data (= ~addr) returned the cycle after an accepted request
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    @(negedge clk);
    acc = ifc.inst_req && ifc.inst_addr_ok;
    a   = ifc.inst_addr;
    if (acc) n_req++;
    if (ifc.FpD_valid && ifc.pD_allowin) begin
      dcount++;
      d_bus = ifc.FpD_BUS;
    end
    @(posedge clk);
    #1;
    ifc.inst_data_ok = acc;
    ifc.inst_rdata   = ~a;
  endtask
  task automatic idle();
    predict_BUS = '0; BTB_stall = 0; predict_error_D = 0; predict_error_E = 0;
    ex_en = 0; ertn_flush = 0;
    br_target_D = 32'h1c000200; br_target_E = 32'h1c000300;
    ex_entry = 32'h1c008000; era = 32'h1c000010;
  endtask
  task automatic do_reset();
    idle();
    ifc.inst_addr_ok = 1; ifc.pD_allowin = 1;
    rstn = 0;
    tick(); tick();
    chk("rst_req", ifc.inst_req, 0);
    chk("rst_valid", ifc.FpD_valid, 0);
    chk("rst_bus", ifc.FpD_BUS, 0);
    rstn = 1; n_req = 0; dcount = 0;
  endtask
  task automatic wait_deliv(input string nm, input logic [31:0] pc);
    int tgt;
    tgt = dcount + 1;
    for (int i = 0; i < 40 && dcount < tgt; i++) tick();
    chk({nm, "_cnt"}, dcount, tgt);
    chk({nm, "_bus"}, d_bus, nbus(pc));
  endtask
  task automatic wait_valid();
    for (int i = 0; i < 40 && !ifc.FpD_valid; i++) tick();
    chk("valid_wait", ifc.FpD_valid, 1);
  endtask
  initial begin
    ifc.inst_data_ok = 0; ifc.inst_rdata = 0; ifc.inst_addr_ok = 1; ifc.pD_allowin = 1;
    rstn = 0; idle();
    vt[0] = '{1, 1, 1, 1, 1, 32'h1c008000};
    vt[1] = '{0, 1, 1, 1, 1, 32'h1c000010};
    vt[2] = '{0, 0, 1, 1, 1, 32'h1c000300};
    vt[3] = '{0, 0, 0, 1, 1, 32'h1c000200};
    vt[4] = '{0, 0, 0, 0, 1, 32'h1c000100};
    vt[5] = '{0, 0, 0, 0, 0, 32'h1c000000};
    vt[6] = '{1, 0, 0, 0, 1, 32'h1c008000};
    vt[7] = '{0, 0, 1, 0, 1, 32'h1c000300};
    for (int i = 0; i < 8; i++) begin
      do_reset();
      ifc.inst_addr_ok = 0;
      ex_en = vt[i].ex; ertn_flush = vt[i].er; predict_error_E = vt[i].pe;
      predict_error_D = vt[i].pd; predict_BUS = {vt[i].pt, 32'h1c000100};
      tick();
      idle();
      chk($sformatf("prio%0d_addr", i), ifc.inst_addr, vt[i].exp);
      chk($sformatf("prio%0d_req", i), ifc.inst_req, 1);
    end
    // sequential fetch
    do_reset();
    wait_deliv("seq0", 32'h1c000000);
    wait_deliv("seq1", 32'h1c000004);
    wait_deliv("seq2", 32'h1c000008);
    // back-pressure holds the buffer
    do_reset();
    ifc.pD_allowin = 0;
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_bus", ifc.FpD_BUS, nbus(32'h1c000000));
      chk("hold_req", ifc.inst_req, 0);
    end
    chk("hold_nreq", n_req, 1);
    ifc.pD_allowin = 1;
    wait_deliv("hold_rel", 32'h1c000000);
    // prediction in WAIT drops data and is applied once across a stall
    do_reset();
    ifc.pD_allowin = 0;
    tick();
    predict_BUS = {1'b1, 32'h1c000100};
    tick();
    wait_valid();
    for (int i = 0; i < 5; i++) tick();
    chk("pred_bus", ifc.FpD_BUS, nbus(32'h1c000100));
    chk("pred_nreq", n_req, 2);
    predict_BUS = '0;
    ifc.pD_allowin = 1;
    wait_deliv("pred_deliv", 32'h1c000100);
    chk("pred_dcount", dcount, 1);
    // exception beats E-stage mispredict
    do_reset();
    wait_deliv("ex_pre", 32'h1c000000);
    ex_en = 1; predict_error_E = 1;
    tick();
    idle();
    wait_deliv("ex_entry", 32'h1c008000);
    // misaligned D target raises ADEF and halts fetch until ertn
    do_reset();
    br_target_D = 32'h1c000042; predict_error_D = 1;
    tick();
    idle();
    for (int i = 0; i < 40 && dcount < 1; i++) tick();
    chk("adef_cnt", dcount, 1);
    chk("adef_bus", d_bus, {32'h1c000042, 32'h0, 1'b1, 1'b1, 8'h08, 1'b0});
    for (int i = 0; i < 6; i++) tick();
    chk("adef_nreq", n_req, 1);
    chk("adef_valid", ifc.FpD_valid, 0);
    ertn_flush = 1;
    tick();
    idle();
    wait_deliv("ertn", 32'h1c000010);
    // BTB stall freezes fetch until a D-stage redirect
    do_reset();
    wait_deliv("btb_pre", 32'h1c000000);
    BTB_stall = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("btb_valid", ifc.FpD_valid, 0);
      chk("btb_req", ifc.inst_req, 0);
      tick();
    end
    BTB_stall = 0;
    #1;
    chk("btb_sticky_req", ifc.inst_req, 0);
    chk("btb_sticky_valid", ifc.FpD_valid, 0);
    predict_error_D = 1;
    tick();
    idle();
    wait_deliv("btb_resume", 32'h1c000200);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
